// File: rtl/cpu_pkg.sv
// cpu_pkg: shared encodings for the multi-cycle MIPS core.
// Opcodes/functs, ALU op and FSM state enums, error codes, decode helpers.
package cpu_pkg;
  localparam logic [5:0] OP_R     = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  localparam logic [31:0] BRK_INST = 32'h0000_000D;

  typedef enum logic [1:0] {
    ERR_NONE, ERR_BRK, ERR_ILL, ERR_BUS
  } err_e;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR,
    ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
  } alu_op_e;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC,
    S_MEM, S_WB, S_HALT
  } state_e;

  function automatic alu_op_e alu_sel(
    input logic [31:0] ir
  );
    alu_sel = ALU_ADD;
    if (ir[31:26] == OP_R) begin
      case (ir[5:0])
        F_SUB, F_SUBU: alu_sel = ALU_SUB;
        F_AND:  alu_sel = ALU_AND;
        F_OR:   alu_sel = ALU_OR;
        F_XOR:  alu_sel = ALU_XOR;
        F_NOR:  alu_sel = ALU_NOR;
        F_SLT:  alu_sel = ALU_SLT;
        F_SLTU: alu_sel = ALU_SLTU;
        F_SLL:  alu_sel = ALU_SLL;
        F_SRL:  alu_sel = ALU_SRL;
        F_SRA:  alu_sel = ALU_SRA;
        default: alu_sel = ALU_ADD;
      endcase
    end else begin
      case (ir[31:26])
        OP_SLTI: alu_sel = ALU_SLT;
        OP_ANDI: alu_sel = ALU_AND;
        OP_ORI:  alu_sel = ALU_OR;
        OP_XORI: alu_sel = ALU_XOR;
        OP_LUI:  alu_sel = ALU_LUI;
        default: alu_sel = ALU_ADD;
      endcase
    end
  endfunction

  function automatic logic legal(
    input logic [31:0] ir
  );
    legal = 1'b0;
    case (ir[31:26])
      OP_R: begin
        case (ir[5:0])
          F_SLL, F_SRL, F_SRA, F_JR,
          F_ADD, F_ADDU, F_SUB, F_SUBU,
          F_AND, F_OR, F_XOR, F_NOR,
          F_SLT, F_SLTU: legal = 1'b1;
          default: legal = 1'b0;
        endcase
      end
      OP_J, OP_JAL, OP_BEQ, OP_BNE,
      OP_ADDI, OP_ADDIU, OP_SLTI,
      OP_ANDI, OP_ORI, OP_XORI,
      OP_LUI, OP_LW, OP_SW: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/mc_regfile.sv
// mc_regfile: 32x32 register file, two async reads, one sync write.
// Ports: ra/rb read addr+data, we/wa/wd write port; $0 reads as zero.
module mc_regfile (
  input  logic        clk,
  input  logic [4:0]  ra_i,
  input  logic [4:0]  rb_i,
  output logic [31:0] ra_o,
  output logic [31:0] rb_o,
  input  logic        we_i,
  input  logic [4:0]  wa_i,
  input  logic [31:0] wd_i
);
  logic [31:0] rf_q [0:31];

  always_ff @(posedge clk) begin
    if (we_i && wa_i != 5'd0) begin
      rf_q[wa_i] <= wd_i;
    end
  end

  assign ra_o = (ra_i == 5'd0) ? '0 : rf_q[ra_i];
  assign rb_o = (rb_i == 5'd0) ? '0 : rf_q[rb_i];
endmodule

// File: rtl/multicycle_cpu.sv
// multicycle_cpu: FSM-sequenced MIPS subset on one req/ready memory port.
// Ports: clk, rst_n, mem_* bus, halted/err_code status, dbg_pc/dbg_inst.
module multicycle_cpu
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0,
  parameter int unsigned MEM_TIMEOUT  = 0,
  parameter bit          OVF_NO_WRITE = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        halted,
  output logic [1:0]  err_code,
  output logic [31:0] dbg_pc,
  output logic [31:0] dbg_inst
);
  state_e      state_q;
  err_e        err_q;
  logic [31:0] pc_q, ir_q, a_q, b_q;
  logic [31:0] imm_q, alu_q, mdr_q, wait_q;
  logic [31:0] addr_q, wdata_q;
  logic        req_q, we_q, halt_q, ovf_q;

  logic [5:0]  op, fn;
  logic [4:0]  rs, rt, rd, sh;
  logic        is_r, is_br, is_j, is_jr;
  logic        is_mem, take, zext;
  logic        trap_op, ovf, tmo;
  logic        rf_we;
  logic [4:0]  rf_wa;
  alu_op_e     alu_op;
  logic [31:0] ra, rb, ext, opb;
  logic [31:0] sum, diff, alu_res;
  logic [31:0] br_tgt, j_tgt, npc, rf_wd;

  assign op = ir_q[31:26];
  assign fn = ir_q[5:0];
  assign rs = ir_q[25:21];
  assign rt = ir_q[20:16];
  assign rd = ir_q[15:11];
  assign sh = ir_q[10:6];

  assign is_r   = (op == OP_R);
  assign is_br  = (op == OP_BEQ) || (op == OP_BNE);
  assign is_j   = (op == OP_J) || (op == OP_JAL);
  assign is_jr  = is_r && (fn == F_JR);
  assign is_mem = (op == OP_LW) || (op == OP_SW);
  assign zext   = (op == OP_ANDI) || (op == OP_ORI)
               || (op == OP_XORI);
  assign ext    = zext ? {16'h0, ir_q[15:0]}
                       : {{16{ir_q[15]}}, ir_q[15:0]};

  assign alu_op = alu_sel(ir_q);
  assign opb    = is_r ? b_q : imm_q;
  assign sum    = a_q + opb;
  assign diff   = a_q - opb;

  // Signed overflow: operands agree (add) or differ (sub) in sign
  // and the result sign departs from A.
  assign trap_op = (is_r && (fn == F_ADD || fn == F_SUB))
                || (op == OP_ADDI);
  assign ovf = (alu_op == ALU_SUB)
    ? (a_q[31] != opb[31]) && (diff[31] != a_q[31])
    : (a_q[31] == opb[31]) && (sum[31] != a_q[31]);

  always_comb begin
    alu_res = sum;
    unique case (alu_op)
      ALU_ADD:  alu_res = sum;
      ALU_SUB:  alu_res = diff;
      ALU_AND:  alu_res = a_q & opb;
      ALU_OR:   alu_res = a_q | opb;
      ALU_XOR:  alu_res = a_q ^ opb;
      ALU_NOR:  alu_res = ~(a_q | opb);
      ALU_SLT:  alu_res = {31'h0, $signed(a_q) < $signed(opb)};
      ALU_SLTU: alu_res = {31'h0, a_q < opb};
      ALU_SLL:  alu_res = b_q << sh;
      ALU_SRL:  alu_res = b_q >> sh;
      ALU_SRA:  alu_res = $signed(b_q) >>> sh;
      ALU_LUI:  alu_res = {imm_q[15:0], 16'h0};
      default:  alu_res = sum;
    endcase
  end

  // pc_q already points past the current instruction here.
  assign take   = (op == OP_BEQ) ? (a_q == b_q) : (a_q != b_q);
  assign br_tgt = pc_q + {imm_q[29:0], 2'b00};
  assign j_tgt  = {pc_q[31:28], ir_q[25:0], 2'b00};
  assign npc    = is_jr ? a_q
                : is_j  ? j_tgt
                : take  ? br_tgt : pc_q;

  assign tmo = (MEM_TIMEOUT != 0)
            && (wait_q == MEM_TIMEOUT - 1);

  // jal links in EXEC; every other write happens in WB.
  always_comb begin
    rf_we = 1'b0;
    rf_wa = is_r ? rd : rt;
    rf_wd = (op == OP_LW) ? mdr_q : alu_q;
    if (state_q == S_EXEC && op == OP_JAL) begin
      rf_we = 1'b1;
      rf_wa = 5'd31;
      rf_wd = pc_q;
    end else if (state_q == S_WB) begin
      rf_we = !(OVF_NO_WRITE && ovf_q);
    end
  end

  mc_regfile u_rf (
    .clk  (clk),
    .ra_i (rs),
    .rb_i (rt),
    .ra_o (ra),
    .rb_o (rb),
    .we_i (rf_we),
    .wa_i (rf_wa),
    .wd_i (rf_wd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      err_q   <= ERR_NONE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      imm_q   <= '0;
      alu_q   <= '0;
      mdr_q   <= '0;
      wait_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      halt_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_FETCH: begin
          if (!req_q) begin
            // first fetch after reset raises req here
            req_q  <= 1'b1;
            we_q   <= 1'b0;
            addr_q <= {pc_q[31:2], 2'b00};
            wait_q <= '0;
          end else if (mem_ready) begin
            ir_q    <= mem_rdata;
            pc_q    <= pc_q + 32'd4;
            req_q   <= 1'b0;
            state_q <= S_DECODE;
          end else if (tmo) begin
            req_q   <= 1'b0;
            halt_q  <= 1'b1;
            err_q   <= ERR_BUS;
            state_q <= S_HALT;
          end else begin
            wait_q <= wait_q + 32'd1;
          end
        end
        S_DECODE: begin
          a_q   <= ra;
          b_q   <= rb;
          imm_q <= ext;
          if (ir_q == BRK_INST) begin
            halt_q  <= 1'b1;
            err_q   <= ERR_BRK;
            state_q <= S_HALT;
          end else if (!legal(ir_q)) begin
            halt_q  <= 1'b1;
            err_q   <= ERR_ILL;
            state_q <= S_HALT;
          end else begin
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          alu_q <= alu_res;
          ovf_q <= trap_op && ovf;
          unique case (1'b1)
            is_br, is_j, is_jr: begin
              pc_q    <= npc;
              req_q   <= 1'b1;
              we_q    <= 1'b0;
              addr_q  <= {npc[31:2], 2'b00};
              wait_q  <= '0;
              state_q <= S_FETCH;
            end
            is_mem: begin
              if (sum[1:0] != 2'b00) begin
                halt_q  <= 1'b1;
                err_q   <= ERR_ILL;
                state_q <= S_HALT;
              end else begin
                req_q   <= 1'b1;
                we_q    <= (op == OP_SW);
                addr_q  <= sum;
                wdata_q <= b_q;
                wait_q  <= '0;
                state_q <= S_MEM;
              end
            end
            default: state_q <= S_WB;
          endcase
        end
        S_MEM: begin
          if (mem_ready) begin
            if (we_q) begin
              // store done: next fetch starts at once
              we_q    <= 1'b0;
              addr_q  <= {pc_q[31:2], 2'b00};
              wait_q  <= '0;
              state_q <= S_FETCH;
            end else begin
              mdr_q   <= mem_rdata;
              req_q   <= 1'b0;
              state_q <= S_WB;
            end
          end else if (tmo) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            halt_q  <= 1'b1;
            err_q   <= ERR_BUS;
            state_q <= S_HALT;
          end else begin
            wait_q <= wait_q + 32'd1;
          end
        end
        S_WB: begin
          req_q   <= 1'b1;
          we_q    <= 1'b0;
          addr_q  <= {pc_q[31:2], 2'b00};
          wait_q  <= '0;
          state_q <= S_FETCH;
        end
        S_HALT: begin
          req_q <= 1'b0;
          we_q  <= 1'b0;
        end
        default: begin
          req_q   <= 1'b0;
          halt_q  <= 1'b1;
          state_q <= S_HALT;
        end
      endcase
    end
  end

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign halted    = halt_q;
  assign err_code  = err_q;
  assign dbg_pc    = pc_q;
  assign dbg_inst  = ir_q;
endmodule
